// File: rtl/tft_line_fetch_ctrl.sv
// tft_line_fetch_ctrl: prefetches display lines in memory bursts into a
// ping-pong line buffer and serves one registered pixel per driver request.
module tft_line_fetch_ctrl #(
  parameter int          H_DISP          = 800,
  parameter int          V_DISP          = 480,
  parameter int          BURST_LEN       = 32,
  parameter int          ADDR_W          = 19,
  parameter int unsigned FB_BASE         = 0,
  parameter logic [15:0] UNDERFLOW_COLOR = 16'hF800
) (
  input  logic              clk_33_3m,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              pix_req,
  output logic [15:0]       pix_data,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic              rd_valid,
  input  logic [15:0]       rd_data,
  output logic              busy,
  output logic              underflow
);
  localparam int PW = $clog2(H_DISP);
  localparam int WW = $clog2(H_DISP + 1);
  localparam int LW = $clog2(V_DISP + 1);
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int AW = $clog2(2 * H_DISP);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_RECV, S_WAIT, S_DONE
  } state_t;

  state_t            state_q;
  logic [LW-1:0]     line_cnt_q;
  logic [WW-1:0]     word_cnt_q;
  logic [BW-1:0]     burst_cnt_q;
  logic              fill_sel_q;
  logic              disp_sel_q;
  logic [1:0]        full_q;
  logic              drain_q;
  logic              rd_req_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [15:0]       pix_data_q;
  logic              underflow_q;
  logic [15:0]       buf_q [2*H_DISP];

  logic          disp_full;
  logic          last_pix;
  logic          release_w;
  logic          other_free;
  logic          drain_act;
  logic          burst_last;
  logic          wr_en;
  logic [WW-1:0] word_nx;
  logic [LW-1:0] line_nx;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;

  function automatic logic [ADDR_W-1:0] addr_f(
    input logic [LW-1:0] ln,
    input logic [WW-1:0] wd
  );
    return ADDR_W'(FB_BASE + 32'(ln) * 32'(H_DISP) + 32'(wd));
  endfunction

  // Buffer ownership, burst progress and buffer addressing.
  always_comb begin
    disp_full  = full_q[disp_sel_q];
    last_pix   = rd_ptr_q == PW'(H_DISP - 1);
    release_w  = pix_req && last_pix && disp_full && !frame_start;
    other_free = !full_q[!fill_sel_q]
               || (release_w && (disp_sel_q != fill_sel_q));
    drain_act  = drain_q || frame_start;
    burst_last = burst_cnt_q == BW'(BURST_LEN - 1);
    word_nx    = word_cnt_q + 1'b1;
    line_nx    = line_cnt_q + 1'b1;
    waddr      = fill_sel_q ? AW'(H_DISP) + AW'(word_cnt_q)
                            : AW'(word_cnt_q);
    raddr      = disp_sel_q ? AW'(H_DISP) + AW'(rd_ptr_q)
                            : AW'(rd_ptr_q);
    wr_en      = (state_q == S_RECV) && rd_valid && !drain_act;
  end

  // Fill FSM: issues bursts, counts words and hands buffers over.
  always_ff @(posedge clk_33_3m) begin
    if (rst) begin
      state_q     <= S_IDLE;
      line_cnt_q  <= '0;
      word_cnt_q  <= '0;
      burst_cnt_q <= '0;
      fill_sel_q  <= 1'b0;
      full_q      <= 2'b00;
      drain_q     <= 1'b0;
      rd_req_q    <= 1'b0;
      rd_addr_q   <= '0;
    end else begin
      if (release_w) full_q[disp_sel_q] <= 1'b0;
      if (frame_start) full_q <= 2'b00;
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (frame_start) begin
            line_cnt_q <= '0;
            word_cnt_q <= '0;
            fill_sel_q <= 1'b0;
            rd_req_q   <= 1'b1;
            rd_addr_q  <= addr_f('0, '0);
            state_q    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (frame_start) drain_q <= 1'b1;
          if (rd_ack) begin
            rd_req_q    <= 1'b0;
            burst_cnt_q <= '0;
            state_q     <= S_RECV;
          end
        end
        S_RECV: begin
          if (frame_start) drain_q <= 1'b1;
          if (rd_valid) begin
            burst_cnt_q <= burst_cnt_q + 1'b1;
            if (!drain_act) word_cnt_q <= word_nx;
            if (burst_last && drain_act) begin
              drain_q    <= 1'b0;
              line_cnt_q <= '0;
              word_cnt_q <= '0;
              fill_sel_q <= 1'b0;
              rd_req_q   <= 1'b1;
              rd_addr_q  <= addr_f('0, '0);
              state_q    <= S_ISSUE;
            end else if (burst_last) begin
              if (word_nx < WW'(H_DISP)) begin
                rd_req_q  <= 1'b1;
                rd_addr_q <= addr_f(line_cnt_q, word_nx);
                state_q   <= S_ISSUE;
              end else begin
                full_q[fill_sel_q] <= 1'b1;
                line_cnt_q <= line_nx;
                word_cnt_q <= '0;
                if (line_nx == LW'(V_DISP)) begin
                  state_q <= S_DONE;
                end else if (other_free) begin
                  fill_sel_q <= !fill_sel_q;
                  rd_req_q   <= 1'b1;
                  rd_addr_q  <= addr_f(line_nx, '0);
                  state_q    <= S_ISSUE;
                end else begin
                  state_q <= S_WAIT;
                end
              end
            end
          end
        end
        S_WAIT: begin
          if (frame_start) begin
            line_cnt_q <= '0;
            word_cnt_q <= '0;
            fill_sel_q <= 1'b0;
            rd_req_q   <= 1'b1;
            rd_addr_q  <= addr_f('0, '0);
            state_q    <= S_ISSUE;
          end else if (other_free) begin
            fill_sel_q <= !fill_sel_q;
            rd_req_q   <= 1'b1;
            rd_addr_q  <= addr_f(line_cnt_q, '0);
            state_q    <= S_ISSUE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Line buffer write port; storage only, so it carries no reset.
  always_ff @(posedge clk_33_3m) begin
    if (!rst && wr_en) buf_q[waddr] <= rd_data;
  end

  // Display side: one registered pixel per request, red on underflow.
  always_ff @(posedge clk_33_3m) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      disp_sel_q  <= 1'b0;
      pix_data_q  <= '0;
      underflow_q <= 1'b0;
    end else if (frame_start) begin
      rd_ptr_q    <= '0;
      disp_sel_q  <= 1'b0;
      underflow_q <= 1'b0;
      if (pix_req) pix_data_q <= UNDERFLOW_COLOR;
    end else if (pix_req) begin
      if (disp_full) begin
        pix_data_q <= buf_q[raddr];
      end else begin
        pix_data_q  <= UNDERFLOW_COLOR;
        underflow_q <= 1'b1;
      end
      if (last_pix) begin
        rd_ptr_q   <= '0;
        disp_sel_q <= !disp_sel_q;
      end else begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  assign pix_data  = pix_data_q;
  assign rd_req    = rd_req_q;
  assign rd_addr   = rd_addr_q;
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign underflow = underflow_q;

endmodule

// File: tb/tb_tft_line_fetch_ctrl.sv
// tb_tft_line_fetch_ctrl: randomized memory responder, pixel driver and
// scoreboards for burst addresses and pixel data against a frame model.
module tb_tft_line_fetch_ctrl;
  localparam int          H     = 64;
  localparam int          V     = 6;
  localparam int          BL    = 8;
  localparam int          AW    = 19;
  localparam int unsigned FB    = 256;
  localparam logic [15:0] UFC   = 16'hF800;
  localparam int          BLANK = 150;
  localparam int          BACK  = 300;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic          pix_req;
  logic [15:0]   pix_data;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ack;
  logic          rd_valid;
  logic [15:0]   rd_data;
  logic          busy;
  logic          underflow;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_pix[$];
  int unsigned exp_addr[$];
  int          bursts = 0;
  int          words_in_burst = 0;
  int          fixed_delay = -1;
  bit          mem_stall = 1'b0;
  logic [15:0] held = 16'h0;
  logic        mon_req = 1'b0;
  logic        mon_rst = 1'b0;

  always #15 clk = ~clk;

  tft_line_fetch_ctrl #(
    .H_DISP(H), .V_DISP(V), .BURST_LEN(BL), .ADDR_W(AW),
    .FB_BASE(FB), .UNDERFLOW_COLOR(UFC)
  ) dut (
    .clk_33_3m(clk), .rst(rst), .frame_start(frame_start),
    .pix_req(pix_req), .pix_data(pix_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .underflow(underflow)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pixel monitor: pops the expected pixel after each request.
  always @(posedge clk) begin
    mon_req = pix_req;
    mon_rst = rst;
  end

  always @(negedge clk) begin
    if (mon_rst) begin
      chk("reset_pix", pix_data, 16'h0);
      held = 16'h0;
    end else if (mon_req) begin
      if (exp_pix.size() == 0) begin
        chk("pix_queue_empty", 32'(exp_pix.size()), 1);
      end else begin
        held = exp_pix.pop_front();
        chk("pix", pix_data, held);
      end
    end else begin
      chk("pix_hold", pix_data, held);
    end
  end

  // Memory responder: acks bursts, returns address-valued words.
  initial begin
    int unsigned a;
    int d;
    int w;
    bit gap;
    rd_ack = 1'b0;
    rd_valid = 1'b0;
    rd_data = 16'h0;
    forever begin
      @(posedge clk); #1;
      rd_ack = 1'b0;
      rd_valid = 1'b0;
      if (rd_req && !mem_stall && !rst) begin
        a = rd_addr;
        d = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
        for (int i = 0; i < d; i++) begin
          @(posedge clk); #1;
          chk("req_hold", rd_req, 1);
          chk("addr_hold", rd_addr, a);
        end
        rd_ack = 1'b1;
        bursts++;
        if (exp_addr.size() == 0)
          chk("addr_queue_empty", 32'(exp_addr.size()), 1);
        else
          chk("burst_addr", rd_addr, exp_addr.pop_front());
        @(posedge clk); #1;
        rd_ack = 1'b0;
        chk("req_drop", rd_req, 0);
        gap = 1'b0;
        w = 0;
        while (w < BL) begin
          if (!gap && $urandom_range(0, 3) == 0) begin
            rd_valid = 1'b0;
            gap = 1'b1;
          end else begin
            rd_valid = 1'b1;
            rd_data = 16'(a + w);
            w++;
            words_in_burst = w;
            gap = 1'b0;
          end
          @(posedge clk); #1;
        end
        rd_valid = 1'b0;
        words_in_burst = 0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_frame(input bit pending);
    exp_addr.delete();
    if (pending) exp_addr.push_back(FB);
    for (int l = 0; l < V; l++)
      for (int b = 0; b < H / BL; b++)
        exp_addr.push_back(FB + l * H + b * BL);
  endtask

  task automatic pulse_fs(input bit with_req);
    frame_start = 1'b1;
    pix_req = with_req;
    if (with_req) exp_pix.push_back(UFC);
    cyc(1);
    frame_start = 1'b0;
    pix_req = 1'b0;
  endtask

  task automatic show_line(input int l, input bit gaps);
    for (int x = 0; x < H; x++) begin
      if (gaps && $urandom_range(0, 7) == 0) begin
        pix_req = 1'b0;
        cyc(1);
      end
      pix_req = 1'b1;
      exp_pix.push_back(16'(FB + l * H + x));
      cyc(1);
    end
    pix_req = 1'b0;
  endtask

  task automatic show_frame(input int first);
    for (int l = first; l < V; l++) begin
      show_line(l, 1'b1);
      cyc(BLANK);
    end
  endtask

  task automatic end_frame(input int exp_bursts);
    cyc(20);
    chk("end_underflow", underflow, 0);
    chk("end_busy", busy, 0);
    chk("end_rd_req", rd_req, 0);
    chk("end_addr_left", 32'(exp_addr.size()), 0);
    chk("end_pix_left", 32'(exp_pix.size()), 0);
    chk("end_bursts", 32'(bursts), 32'(exp_bursts));
  endtask

  task automatic wait_words(input int n, input string name);
    int t = 0;
    while (words_in_burst < n && t < 200) begin
      @(posedge clk); #2;
      t++;
    end
    chk(name, 32'(words_in_burst >= n), 1);
  endtask

  initial begin
    #(60000 * 30);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int waited;
    rst = 1'b1;
    frame_start = 1'b0;
    pix_req = 1'b0;
    cyc(3);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_rd_req", rd_req, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_underflow", underflow, 0);
    rst = 1'b0;
    cyc(2);
    chk("idle_busy", busy, 0);

    // Normal frame with random memory latency.
    expect_frame(1'b0);
    bursts = 0;
    pulse_fs(1'b0);
    chk("run_busy", busy, 1);
    cyc(BACK);
    show_frame(0);
    end_frame(V * H / BL);

    // Fixed 5-cycle ack; display held off until fill parks.
    fixed_delay = 5;
    expect_frame(1'b0);
    bursts = 0;
    pulse_fs(1'b0);
    cyc(500);
    chk("wf_rd_req", rd_req, 0);
    chk("wf_busy", busy, 1);
    chk("wf_bursts", 32'(bursts), 32'(2 * H / BL));
    show_line(0, 1'b0);
    waited = 0;
    while (!rd_req && waited < 2) begin
      cyc(1);
      waited++;
    end
    chk("wf_issue", rd_req, 1);
    chk("wf_addr", rd_addr, FB + 2 * H);
    cyc(BLANK);
    show_frame(1);
    end_frame(V * H / BL);
    fixed_delay = -1;

    // Memory stalled: every pixel of a line underflows.
    mem_stall = 1'b1;
    expect_frame(1'b0);
    bursts = 0;
    pulse_fs(1'b0);
    cyc(5);
    for (int x = 0; x < H; x++) begin
      pix_req = 1'b1;
      exp_pix.push_back(UFC);
      cyc(1);
    end
    pix_req = 1'b0;
    cyc(1);
    chk("uf_set", underflow, 1);
    chk("stall_rd_req", rd_req, 1);
    chk("stall_bursts", 32'(bursts), 0);
    expect_frame(1'b1);
    bursts = 0;
    pulse_fs(1'b1);
    chk("uf_clear", underflow, 0);
    mem_stall = 1'b0;
    cyc(BACK);
    show_frame(0);
    end_frame(V * H / BL + 1);

    // Restart in the middle of the first burst.
    expect_frame(1'b0);
    bursts = 0;
    pulse_fs(1'b0);
    wait_words(3, "mid_wait");
    expect_frame(1'b0);
    bursts = 0;
    pulse_fs(1'b0);
    cyc(BACK);
    show_frame(0);
    end_frame(V * H / BL);

    // Reset in the middle of a burst, stray words still arriving.
    expect_frame(1'b0);
    bursts = 0;
    pulse_fs(1'b0);
    wait_words(4, "rst_wait");
    rst = 1'b1;
    cyc(1);
    chk("mid_rst_rd_req", rd_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_pix", pix_data, 0);
    chk("mid_rst_underflow", underflow, 0);
    rst = 1'b0;
    exp_addr.delete();
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_req", rd_req, 0);
    end

    // Clean frame after reset.
    expect_frame(1'b0);
    bursts = 0;
    pulse_fs(1'b0);
    cyc(BACK);
    show_frame(0);
    end_frame(V * H / BL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
